dbus_sram_responder: RTL
========================

Name: dbus_sram_responder

Overview:
- Memory-side responder for the core's data bus.
- Accepts dbus_req_t from the core's memory stage and returns dbus_resp_t after a fixed, configurable latency.
- Backed by a byte-writable 64-bit-word SRAM model.
- Used as the simulation data memory and as the stub target for bus-protocol verification of the core's memory stage.

Parameters:
- MEM_WORDS, 4096, number of 64-bit words in the array; must be a power of two.
- BASE_ADDR, 64'h8000_0000, byte address of word 0.
- LATENCY, 2, cycles from request acceptance to data_ok; legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- dreq  in  dbus_req_t  valid, addr[63:0], size[2:0], strobe[7:0], data[63:0].
- dresp  out  dbus_resp_t  addr_ok, data_ok, data[63:0].
- err  out  1  sticky error flag; cleared only by reset.
- busy  out  1  high while a transaction is accepted but not yet completed.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, counter=0.
  - dresp all zero, err=0, busy=0.
  - Array contents are not reset.
- State IDLE:
  - If dreq.valid is high, latch addr/size/strobe/data, load counter=LATENCY-1, set busy=1, and go to WAIT.
- State WAIT:
  - If counter!=0, decrement.
  - If counter==0, go to RESP. The registered outputs addr_ok=1, data_ok=1 and data are driven in the RESP cycle.
- State RESP (exactly one cycle):
  - dresp.addr_ok and dresp.data_ok are both 1.
  - Write commit: the write is performed at the RESP edge for byte lanes where strobe bit=1.
  - Next state is IDLE; busy drops.
- Timing and throughput:
  - data_ok is asserted exactly LATENCY cycles after the cycle in which valid was first sampled in IDLE.
  - Minimum spacing between consecutive requests is LATENCY+1 cycles.
- Request type:
  - Read when strobe==0. dresp.data = the full 64-bit word at index (addr-BASE_ADDR)>>3, lane-aligned.
  - Write otherwise. dresp.data returns the pre-write word.
- Address decode:
  - Word index width is log2(MEM_WORDS).
  - Out of range when addr<BASE_ADDR or index>=MEM_WORDS. Then: respond normally with data=0, drop any write, set err=1.
- Misalignment:
  - Misaligned when addr is not aligned to 2^size bytes. Then: respond with data=0, drop any write, set err=1.
- Protocol rule: the initiator holds dreq stable from valid until data_ok.
  - valid falls during WAIT: abort to IDLE, no write, no data_ok, set err=1.
  - Other dreq fields change during WAIT: ignored; the latched copy is used.
- dresp outside RESP: addr_ok=0, data_ok=0, data=0.
- Reset mid-transaction: immediate return to IDLE; a pending write is discarded.

Optional Feature:
- Macro: DBUS_RESP_RANDOM_DELAY_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - On acceptance, counter is loaded with LATENCY-1 + lfsr[1:0], giving 0..3 extra WAIT cycles.
  - All other rules are unchanged.
- When undefined: the latency is exactly LATENCY and no LFSR logic exists.

Decomposition:
- Package dbus_resp_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - function is_misaligned(addr, size);
  - LFSR seed/tap constants.
- dbus_req_t and dbus_resp_t stay in the common package.
- One sub-module, dbus_sram_bank:
  - MEM_WORDS x 64 array;
  - synchronous byte-strobed write;
  - combinational read by index.

Test Plan:
- Read after reset, LATENCY=2: preload word 0 = 64'h1122334455667788; read addr 8000_0000, size=3 → data_ok in cycle t+2 with that data; busy high for cycles t+1..t+2.
- Byte write: strobe=8'h04, data=64'hxxxx_xxxx_xxAB_xxxx to addr 8000_0002, size=0 → later read returns 64'h1122334455AB7788; the write's own response returns the old word.
- Out of range: read addr 7FFF_FFF8 → data_ok with data=0, err=1 and stays 1 until reset.
- Misaligned: size=2 at addr 8000_0002 with strobe=8'h3C → no write (a later read shows the unchanged word), err=1.
- Abort: drop valid one cycle after acceptance with LATENCY=4 → no data_ok within 6 cycles, no write, err=1, state IDLE.
- Async reset mid-WAIT of a write → dresp=0 immediately, memory unchanged; with DBUS_RESP_RANDOM_DELAY_EN, 100 reads each complete within LATENCY..LATENCY+3 cycles.

Source files
------------

// File: rtl/dbus_common_pkg.sv
// Common data-bus types shared between the core's memory stage and its
// targets.
//   dbus_req_t  : valid, addr[63:0], size[2:0] (log2 bytes), strobe[7:0], data[63:0]
//   dbus_resp_t : addr_ok, data_ok, data[63:0]
package dbus_common_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_resp_pkg.sv
// Local definitions for the SRAM-backed data-bus responder:
// FSM state encoding, delay-counter width, LFSR constants for the optional
// random-delay mode, and the alignment helper.
package dbus_resp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  // Holds LATENCY-1 (max 14) plus up to 3 random extra cycles.
  localparam int CNT_W = 5;

  // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // An access of 2^size bytes must start on a 2^size byte boundary.
  function automatic logic is_misaligned(input logic [63:0] addr,
                                         input logic [2:0]  size);
    logic [7:0] mask;
    mask = (8'd1 << size) - 8'd1;
    return (addr[7:0] & mask) != 8'd0;
  endfunction

endpackage

// File: rtl/dbus_sram_bank.sv
// Byte-writable 64-bit-word SRAM model.
//   clk   : write clock
//   we    : write enable, committed on the rising edge
//   widx  : word index for the write
//   wstrb : byte-lane write enables
//   wdata : write data, lane aligned
//   ridx  : word index for the combinational read
//   rdata : word at ridx
// Contents are not reset.
module dbus_sram_bank #(
  parameter int MEM_WORDS = 4096,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [7:0]       wstrb,
  input  logic [63:0]      wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic [63:0]      rdata
);

  logic [63:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (wstrb[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/dbus_sram_responder.sv
// Memory-side responder for the core's data bus, backed by dbus_sram_bank.
// A request sampled in IDLE is answered with addr_ok/data_ok exactly
// LATENCY cycles later (one RESP cycle); writes commit at the end of RESP,
// so a write's response carries the pre-write word.
//   clk   : clock
//   reset : asynchronous, active-high
//   dreq  : request from the memory stage (held stable until data_ok)
//   dresp : registered response, all zero outside RESP
//   err   : sticky error (out of range, misaligned, or valid dropped early)
//   busy  : a transaction is accepted but not yet completed
// Build option: DBUS_RESP_RANDOM_DELAY_EN adds 0..3 LFSR-chosen extra
// wait cycles per transaction.
module dbus_sram_responder
  import dbus_common_pkg::*;
  import dbus_resp_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err,
  output logic       busy
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, load_cnt;
  dbus_req_t        req_q, req_d;
  dbus_resp_t       dresp_q, dresp_d;
  logic             err_q, err_d;
  logic             enter_resp;

  // Decode from the live request while IDLE (LATENCY=1 goes straight to
  // RESP), otherwise from the latched copy.
  logic [63:0]      cur_addr, offset, rdata;
  logic [2:0]       cur_size;
  logic [IDX_W-1:0] idx;
  logic             oor, bad, we;

  assign cur_addr = (state_q == IDLE) ? dreq.addr : req_q.addr;
  assign cur_size = (state_q == IDLE) ? dreq.size : req_q.size;
  assign offset   = cur_addr - BASE_ADDR;
  assign idx      = offset[IDX_W+2:3];
  assign oor      = (cur_addr < BASE_ADDR) || (offset[63:IDX_W+3] != '0);
  assign bad      = oor || is_misaligned(cur_addr, cur_size);

  // In RESP cur_* is the latched request, so bad/idx refer to it.
  assign we = (state_q == RESP) && (req_q.strobe != 8'h00) && !bad;

  dbus_sram_bank #(.MEM_WORDS(MEM_WORDS), .IDX_W(IDX_W)) u_bank (
    .clk   (clk),
    .we    (we),
    .widx  (idx),
    .wstrb (req_q.strobe),
    .wdata (req_q.data),
    .ridx  (idx),
    .rdata (rdata)
  );

`ifdef DBUS_RESP_RANDOM_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d   = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  assign load_cnt = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign load_cnt = CNT_W'(LATENCY - 1);
`endif

  // cnt holds the number of WAIT cycles still to run; the response is
  // registered on the edge that leaves the last WAIT cycle (or IDLE when
  // no wait is needed), so data_ok lands exactly load_cnt+1 cycles after
  // acceptance.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    err_d      = err_q;
    dresp_d    = '0;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (dreq.valid) begin
          req_d = dreq;
          cnt_d = load_cnt;
          if (load_cnt == '0) enter_resp = 1'b1;
          else                state_d    = WAIT;
        end
      end
      WAIT: begin
        if (!dreq.valid) begin
          // Initiator broke the hold rule: abandon without responding.
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else if (cnt_q <= CNT_W'(1)) begin
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      state_d         = RESP;
      cnt_d           = '0;
      dresp_d.addr_ok = 1'b1;
      dresp_d.data_ok = 1'b1;
      dresp_d.data    = bad ? 64'h0 : rdata;
      if (bad) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      dresp_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      dresp_q <= dresp_d;
      err_q   <= err_d;
    end
  end

  assign dresp = dresp_q;
  assign err   = err_q;
  assign busy  = (state_q != IDLE);

  logic unused_ok;
  assign unused_ok = ^{offset[2:0], req_q.valid};

endmodule
